// File: rtl/semester_pkg.sv
// Shared types and constants for the semester tracker.
package semester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_JUDGE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned CREDIT_W     = 6;
    localparam int unsigned PASS_GAIN    = 1;
    localparam int unsigned FAIL_PENALTY = 2;

endpackage

// File: rtl/sat_acc.sv
// Saturating add/subtract accumulator with synchronous clear and enable.
module sat_acc #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         sub,
    input  logic [W-1:0] amt,
    output logic [W-1:0] val
);

    localparam int unsigned WX = W + 1;
    localparam logic [W:0]  MAX_EXT = WX'(MAX);

    logic [W-1:0] val_q, val_d;
    logic [W:0]   sum_c;

    // Clear wins over enable; clamp at 0 on subtract and at MAX on add.
    always_comb begin
        sum_c = {1'b0, val_q} + {1'b0, amt};
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (en) begin
            if (sub) begin
                val_d = (val_q < amt) ? '0 : val_q - amt;
            end else begin
                val_d = (sum_c > MAX_EXT) ? W'(MAX) : sum_c[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/semester_tracker.sv
// Accumulates per-day results over a semester and issues a graduate/expelled verdict.
module semester_tracker
    import semester_pkg::*;
#(
    parameter int unsigned DAYS       = 16,
    parameter int unsigned PASS_NEED  = 12,
    parameter int unsigned FAIL_LIMIT = 3,
    parameter int unsigned CREDIT_MAX = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                day_valid,
    input  logic                day_pass,
    input  logic [1:0]          day_bonus,
    output logic                day_ready,
    output logic                busy,
    output logic [4:0]          day_cnt,
    output logic [4:0]          pass_cnt,
    output logic [2:0]          fail_streak,
    output logic                token,
    output logic [CREDIT_W-1:0] credit,
    output logic                done,
    output logic                graduate,
    output logic                expelled
);

    state_e     state_q, state_d;
    logic [4:0] day_cnt_q, day_cnt_d;
    logic [4:0] pass_cnt_q, pass_cnt_d;
    logic [2:0] streak_q, streak_d;
    logic       token_q, token_d;
    logic       done_q, done_d;
    logic       grad_q, grad_d;
    logic       expel_q, expel_d;

    logic                xfer_c;
    logic                clr_c;
    logic                cred_en_c;
    logic                cred_sub_c;
    logic [CREDIT_W-1:0] cred_amt_c;

    assign xfer_c = day_valid && (state_q == ST_RUN);

    // A covered fail (token spent) leaves credit untouched.
    assign cred_en_c  = xfer_c && (day_pass || !token_q);
    assign cred_sub_c = !day_pass;
    assign cred_amt_c = day_pass ? (CREDIT_W'(PASS_GAIN) + CREDIT_W'(day_bonus))
                                 : CREDIT_W'(FAIL_PENALTY);

    always_comb begin
        state_d    = state_q;
        day_cnt_d  = day_cnt_q;
        pass_cnt_d = pass_cnt_q;
        streak_d   = streak_q;
        token_d    = token_q;
        done_d     = done_q;
        grad_d     = grad_q;
        expel_d    = expel_q;
        clr_c      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    day_cnt_d  = '0;
                    pass_cnt_d = '0;
                    streak_d   = '0;
                    token_d    = 1'b0;
                    done_d     = 1'b0;
                    grad_d     = 1'b0;
                    expel_d    = 1'b0;
                    clr_c      = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer_c) begin
                    day_cnt_d = day_cnt_q + 5'd1;
                    if (day_pass) begin
                        pass_cnt_d = pass_cnt_q + 5'd1;
                        streak_d   = '0;
                        if (day_bonus == 2'd3) token_d = 1'b1;
                    end else if (token_q) begin
                        token_d = 1'b0;
                    end else begin
                        streak_d = streak_q + 3'd1;
                    end
                    // Expulsion takes priority over reaching the last day.
                    if (streak_d == 3'(FAIL_LIMIT)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        grad_d  = 1'b0;
                        expel_d = 1'b1;
                    end else if (day_cnt_d == 5'(DAYS)) begin
                        state_d = ST_JUDGE;
                    end
                end
            end
            ST_JUDGE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                grad_d  = (pass_cnt_q >= 5'(PASS_NEED));
                expel_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            day_cnt_q  <= '0;
            pass_cnt_q <= '0;
            streak_q   <= '0;
            token_q    <= 1'b0;
            done_q     <= 1'b0;
            grad_q     <= 1'b0;
            expel_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            day_cnt_q  <= day_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            streak_q   <= streak_d;
            token_q    <= token_d;
            done_q     <= done_d;
            grad_q     <= grad_d;
            expel_q    <= expel_d;
        end
    end

    sat_acc #(
        .W   (CREDIT_W),
        .MAX (CREDIT_MAX)
    ) u_credit (
        .clk (clk),
        .rst (rst),
        .clr (clr_c),
        .en  (cred_en_c),
        .sub (cred_sub_c),
        .amt (cred_amt_c),
        .val (credit)
    );

    assign day_ready   = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_JUDGE);
    assign day_cnt     = day_cnt_q;
    assign pass_cnt    = pass_cnt_q;
    assign fail_streak = streak_q;
    assign token       = token_q;
    assign done        = done_q;
    assign graduate    = grad_q;
    assign expelled    = expel_q;

endmodule

// File: tb/tb_semester_tracker.sv
// Directed bench for semester_tracker: a per-day vector table plus hand-written corner sequences.
module tb_semester_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       day_valid;
    logic       day_pass;
    logic [1:0] day_bonus;
    logic       day_ready;
    logic       busy;
    logic [4:0] day_cnt;
    logic [4:0] pass_cnt;
    logic [2:0] fail_streak;
    logic       token;
    logic [5:0] credit;
    logic       done;
    logic       graduate;
    logic       expelled;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    semester_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .day_valid   (day_valid),
        .day_pass    (day_pass),
        .day_bonus   (day_bonus),
        .day_ready   (day_ready),
        .busy        (busy),
        .day_cnt     (day_cnt),
        .pass_cnt    (pass_cnt),
        .fail_streak (fail_streak),
        .token       (token),
        .credit      (credit),
        .done        (done),
        .graduate    (graduate),
        .expelled    (expelled)
    );

    typedef struct {
        logic       pass;
        logic [1:0] bonus;
        int         day;
        int         pcnt;
        int         streak;
        int         tok;
        int         cred;
        int         bsy;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_verdict(input string tag, input int d, input int g, input int e, input int b);
        check({tag, " done"}, int'(done), d);
        check({tag, " graduate"}, int'(graduate), g);
        check({tag, " expelled"}, int'(expelled), e);
        check({tag, " busy"}, int'(busy), b);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One transfer: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic send_day(input logic p, input logic [1:0] b);
        @(negedge clk);
        day_valid = 1'b1;
        day_pass  = p;
        day_bonus = b;
        @(posedge clk);
        #1;
        day_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Token / credit walk: each row is one day, expected state after its transfer edge.
        tbl[0]  = '{1'b1, 2'd3,  1, 1, 0, 1, 4, 1};
        tbl[1]  = '{1'b0, 2'd0,  2, 1, 0, 0, 4, 1};
        tbl[2]  = '{1'b0, 2'd0,  3, 1, 1, 0, 2, 1};
        tbl[3]  = '{1'b1, 2'd1,  4, 2, 0, 0, 4, 1};
        tbl[4]  = '{1'b0, 2'd0,  5, 2, 1, 0, 2, 1};
        tbl[5]  = '{1'b1, 2'd2,  6, 3, 0, 0, 5, 1};
        tbl[6]  = '{1'b0, 2'd0,  7, 3, 1, 0, 3, 1};
        tbl[7]  = '{1'b0, 2'd0,  8, 3, 2, 0, 1, 1};
        tbl[8]  = '{1'b1, 2'd0,  9, 4, 0, 0, 2, 1};
        tbl[9]  = '{1'b0, 2'd0, 10, 4, 1, 0, 0, 1};
        tbl[10] = '{1'b0, 2'd0, 11, 4, 2, 0, 0, 1};
        tbl[11] = '{1'b1, 2'd3, 12, 5, 0, 1, 4, 1};
        tbl[12] = '{1'b1, 2'd3, 13, 6, 0, 1, 8, 1};
        tbl[13] = '{1'b0, 2'd0, 14, 6, 0, 0, 8, 1};
        tbl[14] = '{1'b1, 2'd0, 15, 7, 0, 0, 9, 1};
        tbl[15] = '{1'b0, 2'd0, 16, 7, 1, 0, 7, 1};

        rst = 1'b1; start = 1'b0; day_valid = 1'b0; day_pass = 1'b0; day_bonus = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset day_ready", int'(day_ready), 0);
        check("reset day_cnt", int'(day_cnt), 0);
        check("reset credit", int'(credit), 0);
        check_verdict("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores day_valid.
        @(negedge clk);
        day_valid = 1'b1; day_pass = 1'b1; day_bonus = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        day_valid = 1'b0;
        check("idle day_cnt", int'(day_cnt), 0);
        check("idle token", int'(token), 0);

        // Table-driven semester.
        do_start();
        check("start ready", int'(day_ready), 1);
        for (int i = 0; i < 16; i++) begin
            send_day(tbl[i].pass, tbl[i].bonus);
            check($sformatf("tbl%0d day_cnt", i), int'(day_cnt), tbl[i].day);
            check($sformatf("tbl%0d pass_cnt", i), int'(pass_cnt), tbl[i].pcnt);
            check($sformatf("tbl%0d streak", i), int'(fail_streak), tbl[i].streak);
            check($sformatf("tbl%0d token", i), int'(token), tbl[i].tok);
            check($sformatf("tbl%0d credit", i), int'(credit), tbl[i].cred);
            check($sformatf("tbl%0d busy", i), int'(busy), tbl[i].bsy);
        end
        check("tbl judge ready", int'(day_ready), 0);
        check_verdict("tbl judge", 0, 0, 0, 1);
        @(posedge clk); #1;
        check_verdict("tbl final", 1, 0, 0, 0);

        // Defaults: 16 plain passes graduate.
        do_start();
        check("restart day_cnt", int'(day_cnt), 0);
        check("restart credit", int'(credit), 0);
        check("restart done", int'(done), 0);
        for (int i = 0; i < 16; i++) send_day(1'b1, 2'd0);
        check("dflt day_cnt", int'(day_cnt), 16);
        check("dflt pass_cnt", int'(pass_cnt), 16);
        check("dflt credit", int'(credit), 16);
        check_verdict("dflt judge", 0, 0, 0, 1);
        @(posedge clk); #1;
        check_verdict("dflt final", 1, 1, 0, 0);

        // DONE ignores day_valid and holds the verdict.
        @(negedge clk);
        day_valid = 1'b1; day_pass = 1'b0; day_bonus = 2'd0;
        repeat (4) @(posedge clk);
        #1;
        day_valid = 1'b0;
        check("done hold day_cnt", int'(day_cnt), 16);
        check("done hold credit", int'(credit), 16);
        check_verdict("done hold", 1, 1, 0, 0);

        // Three uncovered fails in a row expel on the same edge.
        do_start();
        send_day(1'b1, 2'd0);
        send_day(1'b0, 2'd0);
        send_day(1'b0, 2'd0);
        check("expel pre streak", int'(fail_streak), 2);
        check("expel pre done", int'(done), 0);
        send_day(1'b0, 2'd0);
        check("expel day_cnt", int'(day_cnt), 4);
        check("expel credit", int'(credit), 0);
        check("expel streak", int'(fail_streak), 3);
        check("expel ready", int'(day_ready), 0);
        check_verdict("expel", 1, 0, 1, 0);

        // Boundary: 12 passes, fails never adjacent.
        do_start();
        for (int i = 0; i < 16; i++) send_day((i % 4) != 3, 2'd0);
        check("b12 pass_cnt", int'(pass_cnt), 12);
        @(posedge clk); #1;
        check_verdict("b12", 1, 1, 0, 0);

        // Boundary: 11 passes.
        do_start();
        for (int i = 0; i < 16; i++) send_day((i % 3) != 1, 2'd0);
        check("b11 pass_cnt", int'(pass_cnt), 11);
        @(posedge clk); #1;
        check_verdict("b11", 1, 0, 0, 0);

        // Saturation with day_valid held high straight through JUDGE and DONE.
        do_start();
        @(negedge clk);
        day_valid = 1'b1; day_pass = 1'b1; day_bonus = 2'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 15) check("sat credit15", int'(credit), 60);
            if (k == 16) check_verdict("sat judge", 0, 0, 0, 1);
        end
        day_valid = 1'b0;
        check("sat credit", int'(credit), 63);
        check("sat day_cnt", int'(day_cnt), 16);
        check("sat pass_cnt", int'(pass_cnt), 16);
        check("sat token", int'(token), 1);
        check_verdict("sat final", 1, 1, 0, 0);

        // start pulsed in RUN is ignored; reset mid-semester clears everything.
        do_start();
        for (int i = 0; i < 7; i++) send_day(1'b1, 2'd1);
        check("run credit", int'(credit), 14);
        do_start();
        check("run start day_cnt", int'(day_cnt), 7);
        check("run start credit", int'(credit), 14);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst day_cnt", int'(day_cnt), 0);
        check("rst pass_cnt", int'(pass_cnt), 0);
        check("rst credit", int'(credit), 0);
        check("rst ready", int'(day_ready), 0);
        check_verdict("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post rst ready", int'(day_ready), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
